// File: rtl/config_multi_delay_pkg.sv
// Shared defaults and types for the programmable multi-channel delay line.
// Gold-standard delays used by the sample and symbol alignment paths live here too.
package config_multi_delay_pkg;

  localparam int unsigned WIDTH_DEF     = 18;
  localparam int unsigned NCH_DEF       = 2;
  localparam int unsigned MAX_DELAY_DEF = 63;
  localparam int unsigned DW_DEF        = 8;

  localparam int unsigned SAM_DELAY = 2;
  localparam int unsigned SYM_DELAY = 38;

  typedef enum logic {
    RATE_SAM = 1'b0,
    RATE_SYM = 1'b1
  } rate_e;

endpackage

// File: rtl/config_multi_delay_if.sv
// Stream and control bundle for config_multi_delay.
// The master drives enables, rate, delay and data; the slave returns delayed data and status.
interface config_multi_delay_if
  import config_multi_delay_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DW    = DW_DEF
) ();

  logic                 sam_clk_en;
  logic                 sym_clk_en;
  logic                 rate_sel;
  logic [DW-1:0]        delay;
  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH*WIDTH-1:0] data_out;
  logic                 out_valid;
  logic                 delay_err;

  modport master (
    output sam_clk_en, sym_clk_en, rate_sel, delay, data_in,
    input  data_out, out_valid, delay_err
  );

  modport slave (
    input  sam_clk_en, sym_clk_en, rate_sel, delay, data_in,
    output data_out, out_valid, delay_err
  );

endinterface

// File: rtl/config_multi_delay_delay_ram.sv
// Delay-line storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the fill counter in the top keeps stale entries hidden.
module delay_ram
  import config_multi_delay_pkg::*;
#(
  parameter int W     = NCH_DEF * WIDTH_DEF,
  parameter int DEPTH = MAX_DELAY_DEF + 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/config_multi_delay.sv
// Run-time programmable delay of NCH packed channels by 0..MAX_DELAY rate-enable advances.
// Output is zero-filled until the line holds genuine data; over-range requests clamp and latch an error.
module config_multi_delay
  import config_multi_delay_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int MAX_DELAY = MAX_DELAY_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  config_multi_delay_if.slave bus
);

  localparam int DEPTH = MAX_DELAY + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int VW    = NCH * WIDTH;

  logic          adv;
  logic          over;
  logic [AW-1:0] eff;
  logic [AW-1:0] delay_q, delay_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] diff;
  logic [VW-1:0] ram_rd, tap;
  logic [VW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_comb begin
    adv  = (rate_e'(bus.rate_sel) == RATE_SYM) ? bus.sym_clk_en : bus.sam_clk_en;
    over = bus.delay > DW'(MAX_DELAY);
    eff  = over ? AW'(MAX_DELAY) : bus.delay[AW-1:0];

    // Extra sign bit makes the underflow visible; fold back into the non-power-of-two ring.
    diff   = {1'b0, wr_q} - {1'b0, delay_q};
    rd_ptr = diff[PW-1] ? AW'(diff + PW'(DEPTH)) : diff[AW-1:0];
    tap    = (delay_q == '0) ? bus.data_in : ram_rd;

    wr_d = wr_q;
    if (adv) begin
      wr_d = (wr_q == AW'(MAX_DELAY)) ? '0 : wr_q + 1'b1;
    end
  end

  always_comb begin
    delay_d = delay_q;
    fill_d  = fill_q;
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = err_q | over;
    if (eff != delay_q) begin
      delay_d = eff;
      fill_d  = adv ? AW'(1) : '0;
      valid_d = 1'b0;
      out_d   = '0;
    end else if (adv) begin
      // fill_q counts writes already in the line, so the tap is genuine once it reaches delay_q.
      valid_d = (fill_q >= delay_q);
      out_d   = valid_d ? tap : '0;
      if (fill_q < delay_q) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      fill_q  <= '0;
      delay_q <= eff;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      delay_q <= delay_d;
    end
  end

  delay_ram #(
    .W     (VW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (adv & ~reset),
    .waddr_i (wr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr),
    .rdata_o (ram_rd)
  );

  assign bus.data_out  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.delay_err = err_q;

endmodule
